// File: rtl/risc_core_mh.sv
// risc_core_mh -- accumulator CPU core with an 8-opcode ISA.
//
// Instruction word: opcode = word[DWIDTH-1:DWIDTH-3], operand address = word[AWIDTH-1:0].
// Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
// Memory is external and unified, and is reached over a req/ack handshake.
// The core inserts as many wait states as the memory asks for.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   run        permits a new instruction fetch
//   resume     one-cycle pulse that leaves HALT
//   mem_req    access request; held until the edge where mem_ack=1
//   mem_we     1 = write, 0 = read
//   mem_addr   access address
//   mem_wdata  write data (accumulator during STO)
//   mem_rdata  read data, sampled on the ack edge
//   mem_ack    access completes this edge; ignored while mem_req=0
//   acc        accumulator
//   pc_out     program counter
//   halted     core is in HALT
//   instret    retired-instruction counter, wraps
module risc_core_mh #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DWIDTH-1:0] acc,
  output logic [AWIDTH-1:0] pc_out,
  output logic              halted,
  output logic [CNTW-1:0]   instret
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_DEC  = 3'd1;
  localparam logic [2:0] S_OPRD = 3'd2;
  localparam logic [2:0] S_OPWR = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [AWIDTH-1:0] PC_ONE  = AWIDTH'(1);
  localparam logic [CNTW-1:0]   CNT_ONE = CNTW'(1);

  logic [2:0]        state;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic              fetch_pend;
  logic [2:0]        opcode;
  logic [AWIDTH-1:0] ir_addr;
  logic              retire;
  logic              unused_ir;

  // Computes the accumulator result for an operand read. ADD wraps and discards the carry.
  function automatic logic [DWIDTH-1:0] alu(input logic [2:0] op,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    logic [DWIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = b;
    endcase
    return r;
  endfunction

  assign opcode    = ir[DWIDTH-1 -: 3];
  assign ir_addr   = ir[AWIDTH-1:0];
  // The middle instruction bits carry no meaning.
  assign unused_ir = ^ir;
  assign pc_out    = pc;
  assign halted    = (state == S_HALT);

  // The bus outputs are decoded from state, so a request rises in the same cycle as run.
  // fetch_pend keeps a started fetch alive if run drops before the ack arrives.
  // While reset is asserted, the rst term drops the request at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        S_IF: begin
          mem_req  = run | fetch_pend;
          mem_addr = pc;
        end
        S_OPRD: begin
          mem_req  = 1'b1;
          mem_addr = ir_addr;
        end
        S_OPWR: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ir_addr;
          mem_wdata = acc;
        end
        default: ;
      endcase
    end
  end

  // An instruction retires in DEC when it needs no operand.
  // Otherwise it retires on the edge that acks its operand access.
  always_comb begin
    retire = 1'b0;
    if (state == S_DEC)
      retire = (opcode == OP_HLT) || (opcode == OP_SKZ) || (opcode == OP_JMP);
    else if ((state == S_OPRD) || (state == S_OPWR))
      retire = mem_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instret <= '0;
    else if (retire)
      instret <= instret + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IF;
      pc         <= '0;
      acc        <= '0;
      ir         <= '0;
      fetch_pend <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (mem_req && mem_ack) begin
            ir         <= mem_rdata;
            pc         <= pc + PC_ONE;
            fetch_pend <= 1'b0;
            state      <= S_DEC;
          end else if (mem_req) begin
            fetch_pend <= 1'b1;
          end
        end
        S_DEC: begin
          case (opcode)
            OP_HLT: state <= S_HALT;
            OP_SKZ: begin
              if (acc == '0)
                pc <= pc + PC_ONE;
              state <= S_IF;
            end
            OP_JMP: begin
              pc    <= ir_addr;
              state <= S_IF;
            end
            OP_STO:  state <= S_OPWR;
            default: state <= S_OPRD;
          endcase
        end
        S_OPRD: begin
          if (mem_ack) begin
            acc   <= alu(opcode, acc, mem_rdata);
            state <= S_IF;
          end
        end
        S_OPWR: begin
          if (mem_ack)
            state <= S_IF;
        end
        S_HALT: begin
          if (resume)
            state <= S_IF;
        end
        default: state <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_core_mh.sv
// tb_risc_core_mh -- directed-vector bench for risc_core_mh (DWIDTH=8, AWIDTH=5).
// It models memory with a programmable number of wait states and an optional ack that is
// forced high while no request is pending.
module tb_risc_core_mh;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       resume;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] acc;
  logic [4:0] pc_out;
  logic       halted;
  logic [15:0] instret;

  logic [7:0] mem [0:31];
  int         nwait;
  int         wcnt;
  logic       force_ack;
  int         n_vec;
  int         n_err;
  int         stab_err;
  logic       prev_wait;
  logic [4:0] prev_addr;
  logic       prev_we;

  always #5 clk = ~clk;

  risc_core_mh #(.DWIDTH(8), .AWIDTH(5), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .run(run), .resume(resume),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc(acc), .pc_out(pc_out), .halted(halted), .instret(instret)
  );

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = force_ack | (mem_req && (wcnt == nwait));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
    if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
  end

  // While a request waits for its ack, the request, address and direction must not change.
  always @(negedge clk) begin
    if (rst) begin
      prev_wait <= 1'b0;
    end else begin
      if (prev_wait && (!mem_req || mem_addr != prev_addr || mem_we != prev_we))
        stab_err <= stab_err + 1;
      prev_wait <= mem_req && !mem_ack;
      prev_addr <= mem_addr;
      prev_we   <= mem_we;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic run_v);
    rst       = 1'b1;
    run       = run_v;
    resume    = 1'b0;
    force_ack = 1'b0;
    nwait     = 0;
    for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_ret(input string tag, input int n);
    int k = 0;
    while (instret != 16'(n) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, instret, n);
  endtask

  initial begin
    int cyc;
    int k;
    int base;
    n_vec    = 0;
    n_err    = 0;
    stab_err = 0;
    wcnt     = 0;

    // T1: LDA 30, ADD 31, STO 29, HLT with a zero-wait memory. run is already high during reset.
    rst = 1'b1; run = 1'b1; resume = 1'b0; force_ack = 1'b0; nwait = 0;
    @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_acc", acc, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    do_reset(1'b1);
    mem[0] <= 8'hBE; mem[1] <= 8'h5F; mem[2] <= 8'hDD; mem[3] <= 8'h00;
    mem[30] <= 8'h05; mem[31] <= 8'hFF;
    run_to_halt(cyc);
    chk("t1_cycles", cyc, 11);
    chk("t1_acc", acc, 8'h04);
    chk("t1_mem29", mem[29], 8'h04);
    chk("t1_halted", halted, 1);
    chk("t1_pc", pc_out, 4);
    chk("t1_instret", instret, 4);

    // T2: the same program with 3 wait states on every one of the 7 accesses.
    do_reset(1'b1);
    nwait = 3;
    mem[0] <= 8'hBE; mem[1] <= 8'h5F; mem[2] <= 8'hDD; mem[3] <= 8'h00;
    mem[30] <= 8'h05; mem[31] <= 8'hFF;
    base = stab_err;
    run_to_halt(cyc);
    chk("t2_cycles", cyc, 11 + 3 * 7);
    chk("t2_stable", stab_err - base, 0);
    chk("t2_acc", acc, 8'h04);
    chk("t2_mem29", mem[29], 8'h04);
    chk("t2_pc", pc_out, 4);
    chk("t2_instret", instret, 4);

    // T3a: JMP 31, then SKZ at 31 with acc=0. The fetch wraps pc to 0 and the skip moves it to 1.
    do_reset(1'b1);
    mem[0] <= 8'hFF; mem[31] <= 8'h20;
    wait_ret("t3a_ret1", 1);
    chk("t3a_pc_jmp", pc_out, 31);
    wait_ret("t3a_ret2", 2);
    chk("t3a_pc_skz", pc_out, 1);
    // T3b: LDA 30 (=01), JMP 31, SKZ. There is no skip, so pc wraps to 0.
    do_reset(1'b1);
    mem[0] <= 8'hBE; mem[1] <= 8'hFF; mem[30] <= 8'h01; mem[31] <= 8'h20;
    wait_ret("t3b_ret3", 3);
    chk("t3b_acc", acc, 8'h01);
    chk("t3b_pc", pc_out, 0);

    // T4: run stays low for 10 cycles, then rises. The core halts and resumes.
    do_reset(1'b0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) k++;
    end
    chk("t4_idle_req", k, 0);
    chk("t4_idle_pc", pc_out, 0);
    @(negedge clk);
    run = 1'b1;
    #1;
    chk("t4_req_same_cycle", mem_req, 1);
    run_to_halt(cyc);
    chk("t4_halted", halted, 1);
    chk("t4_pc_halt", pc_out, 1);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    chk("t4_resumed", halted, 0);
    chk("t4_fetch_addr", mem_addr, 1);
    chk("t4_fetch_req", mem_req, 1);
    run_to_halt(cyc);
    chk("t4_pc_halt2", pc_out, 2);
    chk("t4_instret", instret, 2);

    // T5: reset arrives while STO is waiting for its ack.
    do_reset(1'b1);
    nwait = 10;
    mem[0] <= 8'hBE; mem[1] <= 8'hDD; mem[30] <= 8'h05; mem[29] <= 8'h77;
    k = 0;
    while (!(mem_req && mem_we) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reach_opwr", mem_req && mem_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_req_async_drop", mem_req, 0);
    @(negedge clk);
    nwait = 0;
    rst = 1'b0;
    #1;
    chk("t5_fetch_addr", mem_addr, 0);
    chk("t5_fetch_req", mem_req, 1);
    chk("t5_mem29_kept", mem[29], 8'h77);

    // T6: the ack is held high throughout, so it also arrives while no request is pending.
    do_reset(1'b0);
    force_ack = 1'b1;
    mem[0] <= 8'hBF; mem[1] <= 8'h9F; mem[2] <= 8'hFF; mem[31] <= 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_spur_pc", pc_out, 0);
    chk("t6_spur_instret", instret, 0);
    chk("t6_spur_state", halted, 0);
    run = 1'b1;
    wait_ret("t6_ret1", 1);
    chk("t6_lda", acc, 8'hAA);
    wait_ret("t6_ret2", 2);
    chk("t6_xor", acc, 8'h00);
    wait_ret("t6_ret3", 3);
    chk("t6_jmp_pc", pc_out, 31);
    chk("t6_jmp_acc", acc, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
